// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle between decode-side producer and execute-side consumer
// of extended immediates.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [24:0]      in_ins;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport master (
        output in_valid,
        output in_op,
        output in_ins,
        output in_tag,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_imm,
        input  out_tag,
        input  out_err
    );

    modport slave (
        input  in_valid,
        input  in_op,
        input  in_ins,
        input  in_tag,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_imm,
        output out_tag,
        output out_err
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: formats instr[31:7] into an XLEN immediate
// and holds it, with its tag, in a registered 2-entry skid buffer.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input logic         clk,
    input logic         rst_n,
    input logic         flush,
    imm_gen_pipe_if.slave bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        OP_I   = 3'd0,
        OP_S   = 3'd1,
        OP_B   = 3'd2,
        OP_U   = 3'd3,
        OP_J   = 3'd4,
        OP_Z   = 3'd5,
        OP_SH  = 3'd6,
        OP_ILL = 3'd7
    } op_e;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             err;
    } ent_t;

    state_e state_q, state_d;
    ent_t   head_q, head_d;
    ent_t   skid_q, skid_d;
    ent_t   new_e;
    op_e    op;
    logic   [24:0] ins;
    logic   in_rdy;
    logic   out_vld;
    logic   push;
    logic   pop;

    assign op  = op_e'(bus.in_op);
    assign ins = bus.in_ins;

    // Immediate formation; every signed format extends from its top bit.
    always_comb begin
        new_e     = '0;
        new_e.tag = bus.in_tag;
        unique case (op)
            OP_I: begin
                new_e.imm = XLEN'($signed(ins[24:13]));
            end
            OP_S: begin
                new_e.imm = XLEN'($signed({ins[24:18], ins[4:0]}));
            end
            OP_B: begin
                new_e.imm = XLEN'($signed({ins[24], ins[0],
                                           ins[23:18], ins[4:1],
                                           1'b0}));
            end
            OP_U: begin
                new_e.imm = XLEN'($signed({ins[24:5], 12'b0}));
            end
            OP_J: begin
                new_e.imm = XLEN'($signed({ins[24], ins[12:5],
                                           ins[13], ins[23:14],
                                           1'b0}));
            end
            OP_Z: begin
                new_e.imm = XLEN'(ins[12:8]);
            end
            OP_SH: begin
                if (XLEN == 64)
                    new_e.imm = XLEN'(ins[18:13]);
                else
                    new_e.imm = XLEN'(ins[17:13]);
            end
            OP_ILL: begin
                new_e.err = 1'b1;
            end
            default: begin
                new_e.err = 1'b1;
            end
        endcase
    end

    assign in_rdy  = (state_q != TWO);
    assign out_vld = (state_q != EMPTY);
    assign push    = bus.in_valid && in_rdy;
    assign pop     = out_vld && bus.out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        head_d  = new_e;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_d = new_e;
                    end else if (push) begin
                        skid_d  = new_e;
                        state_d = TWO;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        head_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    // Outputs read only registered state and are zeroed when idle.
    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.out_imm   = out_vld ? head_q.imm : '0;
    assign bus.out_tag   = out_vld ? head_q.tag : '0;
    assign bus.out_err   = out_vld ? head_q.err : 1'b0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances driven in lockstep
// against a queue-based reference model.
module tb_imm_gen_pipe;

    logic clk;
    logic rst_n;
    logic flush;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(8)) b32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(8)) b64 ();

    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) u32 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (b32.slave)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) u64 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (b64.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] i32;
        logic [63:0] i64;
        logic [7:0]  tag;
        logic        err;
    } mrec_t;

    typedef struct {
        logic [2:0]  op;
        logic [24:0] ins;
        logic [63:0] e32;
        logic [63:0] e64;
        logic        err;
    } vec_t;

    mrec_t      mq[$];
    logic [7:0] drained[$];
    int         n_chk;
    int         n_fail;

    function automatic logic [63:0] ref_imm(input logic [2:0] op,
                                            input logic [24:0] ins,
                                            input int xlen);
        longint v;
        v = 0;
        case (op)
            3'd0: begin
                v = longint'(ins[24:13]);
                if (v >= 2048) v -= 4096;
            end
            3'd1: begin
                v = longint'(ins[24:18]) * 32 + longint'(ins[4:0]);
                if (v >= 2048) v -= 4096;
            end
            3'd2: begin
                v = longint'(ins[24]) * 4096 + longint'(ins[0]) * 2048
                  + longint'(ins[23:18]) * 32 + longint'(ins[4:1]) * 2;
                if (v >= 4096) v -= 8192;
            end
            3'd3: begin
                v = longint'(ins[24:5]) * 4096;
                if (v >= 64'sh8000_0000) v -= 64'sh1_0000_0000;
            end
            3'd4: begin
                v = longint'(ins[24]) * (longint'(1) << 20)
                  + longint'(ins[12:5]) * 4096
                  + longint'(ins[13]) * 2048
                  + longint'(ins[23:14]) * 2;
                if (v >= (longint'(1) << 20)) v -= (longint'(1) << 21);
            end
            3'd5: v = longint'(ins[12:8]);
            3'd6: v = (xlen == 64) ? longint'(ins[18:13])
                                   : longint'(ins[17:13]);
            default: v = 0;
        endcase
        if (xlen == 32) return {32'h0, v[31:0]};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [74:0] act,
                       input logic [74:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_check();
        logic        ev;
        logic        er;
        mrec_t       h;
        logic [74:0] e32;
        logic [74:0] e64;
        ev = (mq.size() > 0);
        er = (mq.size() < 2);
        h  = '{64'h0, 64'h0, 8'h0, 1'b0};
        if (ev) h = mq[0];
        e32 = {ev, er, h.i32, h.tag, h.err};
        e64 = {ev, er, h.i64, h.tag, h.err};
        chk("model32",
            {b32.out_valid, b32.in_ready, 32'h0, b32.out_imm,
             b32.out_tag, b32.out_err}, e32);
        chk("model64",
            {b64.out_valid, b64.in_ready, b64.out_imm,
             b64.out_tag, b64.out_err}, e64);
    endtask

    task automatic drive(input logic v, input logic [2:0] op,
                         input logic [24:0] ins, input logic [7:0] tag,
                         input logic ordy, input logic fl);
        b32.in_valid = v;   b64.in_valid = v;
        b32.in_op = op;     b64.in_op = op;
        b32.in_ins = ins;   b64.in_ins = ins;
        b32.in_tag = tag;   b64.in_tag = tag;
        b32.out_ready = ordy;
        b64.out_ready = ordy;
        flush = fl;
    endtask

    // One clock: drive at negedge, advance model, check at next negedge.
    task automatic cycle(input logic v, input logic [2:0] op,
                         input logic [24:0] ins, input logic [7:0] tag,
                         input logic ordy, input logic fl);
        mrec_t r;
        logic  pu;
        logic  po;
        if (b32.out_valid && ordy && !fl) drained.push_back(b32.out_tag);
        drive(v, op, ins, tag, ordy, fl);
        if (fl) begin
            mq.delete();
        end else begin
            pu = v && (mq.size() < 2);
            po = ordy && (mq.size() > 0);
            if (po) void'(mq.pop_front());
            if (pu) begin
                r.i32 = ref_imm(op, ins, 32);
                r.i64 = ref_imm(op, ins, 64);
                r.tag = tag;
                r.err = (op == 3'd7);
                mq.push_back(r);
            end
        end
        @(negedge clk);
        model_check();
    endtask

    vec_t vt[9];

    initial begin
        logic [7:0] d[3];
        n_chk  = 0;
        n_fail = 0;
        vt[0] = '{3'd0, 25'h1FFE001, 64'hFFFF_FFFF,
                  64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vt[1] = '{3'd3, 25'h02468A1, 64'h1234_5000,
                  64'h0000_0000_1234_5000, 1'b0};
        vt[2] = '{3'd3, 25'h1000000, 64'h8000_0000,
                  64'hFFFF_FFFF_8000_0000, 1'b0};
        vt[3] = '{3'd6, 25'h007E000, 64'd31, 64'd63, 1'b0};
        vt[4] = '{3'd5, 25'h1001F00, 64'h1F, 64'h1F, 1'b0};
        vt[5] = '{3'd7, 25'h1FFFFFF, 64'h0, 64'h0, 1'b1};
        vt[6] = '{3'd1, 25'h1FC001C, 64'hFFFF_FFFC,
                  64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
        vt[7] = '{3'd2, 25'h1FC001F, 64'hFFFF_FFFE,
                  64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
        vt[8] = '{3'd4, 25'h0002000, 64'h800, 64'h800, 1'b0};

        rst_n = 1'b0;
        drive(1'b0, 3'd0, 25'h0, 8'h0, 1'b0, 1'b0);
        #1;
        model_check();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back vectors with the consumer always ready
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, vt[i].op, vt[i].ins, 8'(8'h40 + i), 1'b1, 1'b0);
            chk("vec32", {11'h0, b32.out_valid, b32.out_err, 32'h0,
                          b32.out_imm, 8'h0},
                {11'h0, 1'b1, vt[i].err, vt[i].e32, 8'h0});
            chk("vec64", {11'h0, b64.out_valid, b64.out_err,
                          b64.out_imm, b64.out_tag},
                {11'h0, 1'b1, vt[i].err, vt[i].e64, 8'(8'h40 + i)});
        end
        cycle(1'b0, 3'd0, 25'h0, 8'h0, 1'b1, 1'b0);

        // Back-pressure: three beats against a stalled consumer
        drained.delete();
        cycle(1'b1, 3'd0, 25'h1FFE001, 8'd1, 1'b0, 1'b0);
        cycle(1'b1, 3'd1, 25'h1FC001C, 8'd2, 1'b0, 1'b0);
        cycle(1'b1, 3'd3, 25'h02468A1, 8'd3, 1'b0, 1'b0);
        chk("bp_ready", 75'(b32.in_ready), 75'(0));
        chk("bp_head", 75'({b32.out_tag, b32.out_imm}),
            75'({8'd1, 32'hFFFF_FFFF}));
        cycle(1'b1, 3'd3, 25'h02468A1, 8'd3, 1'b0, 1'b0);
        chk("bp_hold", 75'({b32.out_tag, b32.out_imm}),
            75'({8'd1, 32'hFFFF_FFFF}));
        cycle(1'b1, 3'd3, 25'h02468A1, 8'd3, 1'b1, 1'b0);
        cycle(1'b1, 3'd3, 25'h02468A1, 8'd3, 1'b1, 1'b0);
        cycle(1'b0, 3'd0, 25'h0, 8'h0, 1'b1, 1'b0);
        cycle(1'b0, 3'd0, 25'h0, 8'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            d[i] = (i < drained.size()) ? drained[i] : 8'hFF;
        chk("bp_order", 75'({drained.size(), d[0], d[1], d[2]}),
            75'({32'd3, 8'd1, 8'd2, 8'd3}));

        // Flush with two buffered and a beat presented the same cycle
        cycle(1'b1, 3'd0, 25'h0001000, 8'h10, 1'b0, 1'b0);
        cycle(1'b1, 3'd0, 25'h0002000, 8'h11, 1'b0, 1'b0);
        cycle(1'b1, 3'd0, 25'h0003000, 8'h12, 1'b0, 1'b1);
        chk("flush_state", 75'({b32.out_valid, b32.in_ready,
                                b64.out_valid, b64.in_ready}),
            75'(4'b0101));
        drained.delete();
        cycle(1'b0, 3'd0, 25'h0, 8'h0, 1'b1, 1'b0);
        cycle(1'b0, 3'd0, 25'h0, 8'h0, 1'b1, 1'b0);
        cycle(1'b0, 3'd0, 25'h0, 8'h0, 1'b1, 1'b0);
        chk("flush_drop", 75'(drained.size()), 75'(0));

        // Asynchronous reset while beats are stalled in the buffer
        cycle(1'b1, 3'd7, 25'h1234567, 8'h21, 1'b0, 1'b0);
        chk("err_beat", 75'({b32.out_err, b32.out_imm, b64.out_imm}),
            75'({1'b1, 32'h0, 64'h0}));
        cycle(1'b1, 3'd4, 25'h0ABCDEF, 8'h22, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete();
        chk("async_rst", 75'({b32.out_valid, b64.out_valid}), 75'(0));
        model_check();
        drive(1'b0, 3'd0, 25'h0, 8'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0),
                  3'($urandom_range(0, 7)),
                  25'($urandom),
                  8'($urandom),
                  1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 19) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the decode-stage immediate generator.
- Takes instr[31:7] plus an immediate-format select. Produces an XLEN-wide extended immediate through a registered 2-entry skid buffer with valid/ready handshakes on both sides.
- Sits between fetch/decode and the pipelined execute stage, and carries a sideband tag (PC/ROB id) aligned with each immediate.
- Adds RV64 support, CSR zimm, shift-amount formats, illegal-select flagging, flush and back-pressure.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- TAG_W, 8, width of the sideband tag carried alongside each immediate.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous discard of all buffered entries.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_op  in  3  format select: 0 I, 1 S, 2 B, 3 U, 4 J, 5 Z (CSR zimm), 6 SH (shamt), 7 illegal.
- in_ins  in  25  instr[31:7]; bit 24 is instr[31].
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts output this cycle.
- out_imm  out  XLEN  extended immediate.
- out_tag  out  TAG_W  tag of the current output beat.
- out_err  out  1  beat was generated from in_op = 7.

Behaviour:
- Reset (rst_n low, asynchronous): both entries invalid; out_valid = 0, out_imm = 0, out_tag = 0, out_err = 0, in_ready = 1.
- Formats. s = in_ins[24]; sign extension fills to XLEN:
  - I: sext(ins[24:13]).
  - S: sext({ins[24:18], ins[4:0]}).
  - B: sext({ins[24], ins[0], ins[23:18], ins[4:1], 0}).
  - U: sext({ins[24:5], 12'b0}) from bit 31. For XLEN = 64, bits 63:32 = s.
  - J: sext({ins[24], ins[12:5], ins[13], ins[23:14], 0}).
  - Z: zero-extended ins[12:8] (the rs1 field).
  - SH: zero-extended ins[17:13] for XLEN = 32; ins[18:13] for XLEN = 64.
  - Op 7: imm = 0, err = 1. All other ops give err = 0.
- Extension is combinational into the buffer. There is no combinational path from in_* to out_*.
- Buffer structure:
  - Two-entry FIFO: head entry drives out_*, skid entry behind it.
  - Count is 0..2.
  - in_ready = (count < 2), registered (derived from the state register only).
  - Input accept when in_valid && in_ready. Output pop when out_valid && out_ready.
- Latency and throughput:
  - Beat accepted in cycle N appears on out_* in cycle N+1 if the buffer was empty, or when the prior beat pops.
  - Throughput is 1 beat/cycle while out_ready is held high.
- Simultaneous push and pop:
  - count = 1: count stays 1 and the head is replaced by the new beat.
  - count = 2: illegal, because in_ready = 0. Pop only occurs; the skid entry moves to the head and count becomes 1.
- out_* hold stable while out_valid && !out_ready. The output must not change until it is popped.
- Flush:
  - All entries are invalidated at the next edge, and count becomes 0.
  - Flush has priority over a same-cycle accept: an input beat presented with flush is dropped.
  - Flush does not count as a pop. out_valid = 0 the following cycle.
- Reset mid-operation: immediate return to the reset state; in-flight beats are lost.
- State machine on count: EMPTY(0) → ONE(1) on push. ONE → TWO(2) on push without pop. ONE → EMPTY on pop without push. TWO → ONE on pop. Any state → EMPTY on flush.
- Data fields of invalid entries are don't-care internally, but out_imm, out_tag and out_err are driven to 0 whenever out_valid = 0.

Test Plan:
- XLEN=32, in_op=I, in_ins=0x1FFE001 (addi x1,x0,-1), out_ready=1 → next cycle out_valid=1, out_imm=0xFFFFFFFF, out_err=0, out_tag equal to the input tag.
- XLEN=32, in_op=U, in_ins=0x02468A1 (lui 0x12345) → out_imm=0x12345000. Same stimulus with XLEN=64 and ins[24]=1 (lui 0x80000) → out_imm=0xFFFFFFFF80000000.
- XLEN=64, SH with ins[18:13]=63 → out_imm=63. XLEN=32 with the same ins → out_imm=31, because bit 18 is ignored. Z with ins[12:8]=0x1F → 0x1F with no sign extension.
- Back-pressure: out_ready=0 while pushing 3 beats (tags 1, 2, 3):
  - in_ready drops to 0 after the 2nd accept, and beat 3 is held off.
  - out_* stay on tag 1.
  - Raising out_ready drains tags 1, 2, 3 in order with no loss or duplication.
- Flush with count=2 and in_valid=1 in the same cycle → next cycle out_valid=0, count=0, in_ready=1; the flushed beat's tag never appears on the output.
- in_op=7 → out_err=1, out_imm=0. Assert rst_n low mid-stream with out_ready=0 → out_valid=0 immediately, without waiting for a clock edge.
